// File: rtl/i2c_cmd_arbiter.sv
// Shares one I2C write controller among NUM_REQ requesters: arbitration, NACK retry, per-attempt watchdog.
// Define I2C_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
//
// state   | meaning
// IDLE    | no transfer; grant the next requester and latch its word
// ARM     | GO high, waiting for a stale END from the previous transfer to clear
// RUN     | GO high, waiting for END; ACK captured when END arrives
// DROP    | GO low, waiting for END to clear
// EVAL    | finish on ACK, retry or give up on NACK
// DONE    | one-cycle done/err pulse to the grantee
// RECOVER | after a timeout: wait for END low or a second timeout window
module i2c_cmd_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [24*NUM_REQ-1:0] data_i,
  output logic [NUM_REQ-1:0]    done_o,
  output logic [NUM_REQ-1:0]    err_o,
  output logic                  busy_o,
  output logic [23:0]           i2c_data_o,
  output logic                  i2c_go_o,
  input  logic                  i2c_end_i,
  input  logic                  i2c_ack_i
);

  localparam int          PTR_W    = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_RUN, S_DROP, S_EVAL, S_DONE, S_RECOVER
  } state_t;

  state_t                 state;
  logic [PTR_W-1:0]       grant;
  logic [PTR_W-1:0]       sel;
  logic [2:0]             retry_cnt;
  logic [31:0]            tmr;
  logic                   ack_cap;
  logic [SYNC_STAGES-1:0] end_sync;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   end_s;
  logic                   ack_s;
  logic                   any_req;

  // END and ACK come from the controller's slow clock domain
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      end_sync <= '0;
      ack_sync <= '0;
    end else begin
      end_sync <= {end_sync[SYNC_STAGES-2:0], i2c_end_i};
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], i2c_ack_i};
    end
  end

  assign end_s   = end_sync[SYNC_STAGES-1];
  assign ack_s   = ack_sync[SYNC_STAGES-1];
  assign any_req = |req_i;

`ifdef I2C_ARB_FIXED_PRIO_EN
  always_comb begin
    sel = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) sel = PTR_W'(i);
    end
  end
`else
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((32'(rr_ptr) + 32'(i)) % 32'(NUM_REQ));
      if (!found && req_i[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)
      rr_ptr <= '0;
    else if (state == S_IDLE && any_req)
      rr_ptr <= (32'(sel) == 32'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
  end
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= S_IDLE;
      grant      <= '0;
      retry_cnt  <= '0;
      tmr        <= '0;
      ack_cap    <= 1'b0;
      done_o     <= '0;
      err_o      <= '0;
      busy_o     <= 1'b0;
      i2c_go_o   <= 1'b0;
      i2c_data_o <= '0;
    end else begin
      done_o <= '0;
      err_o  <= '0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            grant      <= sel;
            i2c_data_o <= data_i[24*sel +: 24];
            retry_cnt  <= '0;
            tmr        <= '0;
            busy_o     <= 1'b1;
            i2c_go_o   <= 1'b1;
            state      <= S_ARM;
          end
        end
        S_ARM, S_RUN, S_DROP: begin
          tmr <= tmr + 32'd1;
          if (tmr == TMO_LAST) begin
            i2c_go_o <= 1'b0;
            tmr      <= '0;
            state    <= S_RECOVER;
          end else if (state == S_ARM) begin
            if (!end_s) state <= S_RUN;
          end else if (state == S_RUN) begin
            if (end_s) begin
              ack_cap  <= ack_s;
              i2c_go_o <= 1'b0;
              state    <= S_DROP;
            end
          end else if (!end_s) begin
            state <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (!ack_cap) begin
            done_o[grant] <= 1'b1;
            busy_o        <= 1'b0;
            state         <= S_DONE;
          end else if (32'(retry_cnt) < 32'(MAX_RETRY)) begin
            retry_cnt <= retry_cnt + 3'd1;
            tmr       <= '0;
            i2c_go_o  <= 1'b1;
            state     <= S_ARM;
          end else begin
            done_o[grant] <= 1'b1;
            err_o[grant]  <= 1'b1;
            busy_o        <= 1'b0;
            state         <= S_DONE;
          end
        end
        S_RECOVER: begin
          tmr <= tmr + 32'd1;
          if (!end_s || tmr == TMO_LAST) begin
            done_o[grant] <= 1'b1;
            err_o[grant]  <= 1'b1;
            busy_o        <= 1'b0;
            state         <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
